muldiv_sequencer: RTL and testbench

MULDIV_SEQUENCER -- requirements
Module: muldiv_sequencer

---
 rtl/muldiv_sequencer.sv | 231 +++++++++++++++++++++++
 tb/tb_muldiv_sequencer.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_sequencer.sv
// Multiply/divide sequencer owning the architectural HI/LO registers.
// Multiplies use a shift-add loop and divides use a restoring loop, one
// bit per cycle over unsigned magnitudes. The FIX state then restores the
// signs and commits the result.
//
// state | meaning
// IDLE  | waiting for a request; MTHI/MTLO write HI/LO directly
// MUL   | shift-add multiply, one multiplier bit per cycle
// DIV   | restoring divide, one quotient bit per cycle
// FIX   | sign correction and commit of HI/LO (divide-by-zero holds here)
module muldiv_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             md_i_clk,
  input  logic             md_i_rst,
  input  logic             md_i_start,
  input  logic [2:0]       md_i_op,
  input  logic [WIDTH-1:0] md_i_a,
  input  logic [WIDTH-1:0] md_i_b,
  input  logic             md_i_flush,
  output logic             md_o_busy,
  output logic             md_o_done,
  output logic [WIDTH-1:0] md_o_hi,
  output logic [WIDTH-1:0] md_o_lo
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    FIX  = 2'd3
  } state_t;

  state_t state_q, state_d;

  // Working register: MUL holds {partial product, remaining multiplier};
  // DIV holds {partial remainder, dividend/quotient}.
  logic [2*WIDTH-1:0] acc_q;
  logic [WIDTH-1:0]   opnd_q;     // multiplicand or divisor magnitude
  logic [CW-1:0]      cnt_q;
  logic               neg_res_q;  // negate product / quotient
  logic               neg_rem_q;  // negate remainder
  logic               is_div_q;
  logic               div0_q;
  logic [WIDTH-1:0]   hi_q, lo_q;
  logic               done_q;

  logic accept_mul, accept_div, accept_div0, write_hi, write_lo;
  logic step, fix_hold, commit;

  logic             signed_op;
  logic [WIDTH-1:0] a_mag, b_mag;

  logic [WIDTH-1:0]   mul_addend;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH:0]     div_shift;
  logic               div_ge;
  logic [WIDTH-1:0]   div_rem;
  logic [2*WIDTH-1:0] div_next;

  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   res_hi, res_lo;

  // Operand magnitudes for the signed ops; unsigned ops pass through raw.
  always_comb begin
    signed_op = (md_i_op == OP_MULT) || (md_i_op == OP_DIV);
    a_mag = (signed_op && md_i_a[WIDTH-1]) ? ('0 - md_i_a) : md_i_a;
    b_mag = (signed_op && md_i_b[WIDTH-1]) ? ('0 - md_i_b) : md_i_b;
  end

  // One iteration of the shift-add multiply and of the restoring divide.
  always_comb begin
    mul_addend = acc_q[0] ? opnd_q : '0;
    mul_sum    = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, mul_addend};
    mul_next   = {mul_sum, acc_q[WIDTH-1:1]};
    div_shift  = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    div_ge     = div_shift >= {1'b0, opnd_q};
    div_rem    = div_ge ? (div_shift[WIDTH-1:0] - opnd_q) : div_shift[WIDTH-1:0];
    div_next   = {div_rem, acc_q[WIDTH-2:0], div_ge};
  end

  // Sign correction and result selection used at commit.
  always_comb begin
    prod_fix = neg_res_q ? ('0 - acc_q) : acc_q;
    res_hi   = prod_fix[2*WIDTH-1:WIDTH];
    res_lo   = prod_fix[WIDTH-1:0];
    if (div0_q) begin
      res_hi = acc_q[WIDTH-1:0];
      res_lo = '1;
    end else if (is_div_q) begin
      res_hi = neg_rem_q ? ('0 - acc_q[2*WIDTH-1:WIDTH]) : acc_q[2*WIDTH-1:WIDTH];
      res_lo = neg_res_q ? ('0 - acc_q[WIDTH-1:0]) : acc_q[WIDTH-1:0];
    end
  end

  // Next-state and control decode; flush always wins over start.
  always_comb begin
    state_d     = state_q;
    accept_mul  = 1'b0;
    accept_div  = 1'b0;
    accept_div0 = 1'b0;
    write_hi    = 1'b0;
    write_lo    = 1'b0;
    step        = 1'b0;
    fix_hold    = 1'b0;
    commit      = 1'b0;
    case (state_q)
      IDLE: begin
        if (md_i_start && !md_i_flush) begin
          case (md_i_op)
            OP_MULT, OP_MULTU: begin
              accept_mul = 1'b1;
              state_d    = MUL;
            end
            OP_DIV, OP_DIVU: begin
              if (md_i_b == '0) begin
                accept_div0 = 1'b1;
                state_d     = FIX;
              end else begin
                accept_div = 1'b1;
                state_d    = DIV;
              end
            end
            OP_MTHI: write_hi = 1'b1;
            OP_MTLO: write_lo = 1'b1;
            default: ;
          endcase
        end
      end
      MUL, DIV: begin
        if (md_i_flush) begin
          state_d = IDLE;
        end else begin
          step = 1'b1;
          if (cnt_q == CNT_LAST) state_d = FIX;
        end
      end
      FIX: begin
        if (md_i_flush) begin
          state_d = IDLE;
        end else if (div0_q && cnt_q == '0) begin
          // Divide-by-zero dwells one extra cycle so it commits two edges
          // after acceptance.
          fix_hold = 1'b1;
        end else begin
          commit  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge md_i_clk or posedge md_i_rst) begin
    if (md_i_rst) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Datapath, iteration counter and architectural HI/LO.
  always_ff @(posedge md_i_clk or posedge md_i_rst) begin
    if (md_i_rst) begin
      acc_q     <= '0;
      opnd_q    <= '0;
      cnt_q     <= '0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      is_div_q  <= 1'b0;
      div0_q    <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
    end else begin
      done_q <= commit;
      if (accept_mul) begin
        acc_q     <= {{WIDTH{1'b0}}, b_mag};
        opnd_q    <= a_mag;
        cnt_q     <= '0;
        neg_res_q <= signed_op & (md_i_a[WIDTH-1] ^ md_i_b[WIDTH-1]);
        neg_rem_q <= 1'b0;
        is_div_q  <= 1'b0;
        div0_q    <= 1'b0;
      end
      if (accept_div) begin
        acc_q     <= {{WIDTH{1'b0}}, a_mag};
        opnd_q    <= b_mag;
        cnt_q     <= '0;
        neg_res_q <= signed_op & (md_i_a[WIDTH-1] ^ md_i_b[WIDTH-1]);
        neg_rem_q <= signed_op & md_i_a[WIDTH-1];
        is_div_q  <= 1'b1;
        div0_q    <= 1'b0;
      end
      if (accept_div0) begin
        acc_q     <= {{WIDTH{1'b0}}, md_i_a};
        cnt_q     <= '0;
        neg_res_q <= 1'b0;
        neg_rem_q <= 1'b0;
        is_div_q  <= 1'b1;
        div0_q    <= 1'b1;
      end
      if (step) begin
        acc_q <= (state_q == DIV) ? div_next : mul_next;
        cnt_q <= cnt_q + 1'b1;
      end
      if (fix_hold) cnt_q <= cnt_q + 1'b1;
      if (write_hi) hi_q <= md_i_a;
      if (write_lo) lo_q <= md_i_a;
      if (commit) begin
        hi_q <= res_hi;
        lo_q <= res_lo;
      end
    end
  end

  assign md_o_busy = (state_q != IDLE);
  assign md_o_done = done_q;
  assign md_o_hi   = hi_q;
  assign md_o_lo   = lo_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed plus random bench for muldiv_sequencer against an arithmetic
// reference model of HI/LO and the expected commit latency.
module tb_muldiv_sequencer;

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  logic        clk = 1'b0;
  logic        rst, start, flush;
  logic [2:0]  op;
  logic [31:0] a, b;
  logic        busy, done;
  logic [31:0] hi, lo;

  logic [31:0] m_hi, m_lo;
  int checks = 0;
  int errors = 0;

  muldiv_sequencer #(.WIDTH(32)) dut (
    .md_i_clk  (clk),
    .md_i_rst  (rst),
    .md_i_start(start),
    .md_i_op   (op),
    .md_i_a    (a),
    .md_i_b    (b),
    .md_i_flush(flush),
    .md_o_busy (busy),
    .md_o_done (done),
    .md_o_hi   (hi),
    .md_o_lo   (lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Architectural {HI,LO} after an op, from plain arithmetic.
  function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] x,
                                        input logic [31:0] y, input logic [63:0] prev);
    longint sx, sy, q, r;
    logic [63:0] res;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    case (o)
      OP_MULT:  res = sx * sy;
      OP_MULTU: res = {32'b0, x} * {32'b0, y};
      OP_DIV: begin
        if (y == 0) res = {x, 32'hFFFF_FFFF};
        else begin
          q = sx / sy;
          r = sx % sy;
          res = {r[31:0], q[31:0]};
        end
      end
      OP_DIVU: begin
        if (y == 0) res = {x, 32'hFFFF_FFFF};
        else        res = {x % y, x / y};
      end
      OP_MTHI: res = {x, prev[31:0]};
      OP_MTLO: res = {prev[63:32], x};
      default: res = prev;
    endcase
    return res;
  endfunction

  task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    @(negedge clk);
    start = 1'b1;
    op = o;
    a = x;
    b = y;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic do_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                       input string tag);
    logic [63:0] exp;
    int n, lat;
    bit busy_ok;
    exp = model(o, x, y, {m_hi, m_lo});
    issue(o, x, y);
    if (o inside {OP_MULT, OP_MULTU, OP_DIV, OP_DIVU}) begin
      lat = ((o == OP_DIV || o == OP_DIVU) && y == 0) ? 2 : 33;
      n = 0;
      busy_ok = 1'b1;
      while (!done && n < 100) begin
        if (!busy) busy_ok = 1'b0;
        @(posedge clk);
        #1;
        n++;
      end
      check({tag, "_latency"}, 64'(n), 64'(lat));
      check({tag, "_busy_held"}, 64'(busy_ok), 64'd1);
      check({tag, "_busy_after"}, 64'(busy), 64'd0);
      check({tag, "_result"}, {hi, lo}, exp);
      @(posedge clk);
      #1;
      check({tag, "_done_one_cycle"}, 64'(done), 64'd0);
    end else begin
      check({tag, "_busy"}, 64'(busy), 64'd0);
      check({tag, "_done"}, 64'(done), 64'd0);
      check({tag, "_result"}, {hi, lo}, exp);
    end
    {m_hi, m_lo} = exp;
  endtask

  initial begin
    logic [63:0] exp;
    int n;
    bit seen_done;
    logic [2:0] r_op;
    logic [31:0] r_a, r_b;

    rst = 1'b1; start = 1'b0; flush = 1'b0; op = '0; a = '0; b = '0;
    m_hi = '0; m_lo = '0;
    #12;
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    check("reset_hilo", {hi, lo}, 64'd0);
    #5 rst = 1'b0;

    // Accepted on the first rising edge after reset release.
    do_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu_max");
    check("multu_max_const", {hi, lo}, 64'hFFFF_FFFE_0000_0001);
    do_op(OP_MULT, 32'hFFFF_FFFD, 32'd7, "mult_neg");
    check("mult_neg_const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFEB);
    do_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, "div_neg");
    check("div_neg_const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
    do_op(OP_DIVU, 32'd7, 32'd0, "divu_zero");
    check("divu_zero_const", {hi, lo}, 64'h0000_0007_FFFF_FFFF);
    do_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
    check("div_ovf_const", {hi, lo}, 64'h0000_0000_8000_0000);
    do_op(OP_MTLO, 32'h1234_5678, 32'd0, "mtlo");
    check("mtlo_const", 64'(lo), 64'h1234_5678);
    do_op(OP_MTHI, 32'hCAFE_F00D, 32'd0, "mthi");
    do_op(3'b110, 32'h1111_1111, 32'h2222_2222, "reserved6");
    do_op(3'b111, 32'h3333_3333, 32'd0, "reserved7");

    // Start while busy is ignored; the first result stands.
    exp = model(OP_MULT, 32'hFFFF_FF00, 32'd300, {m_hi, m_lo});
    issue(OP_MULT, 32'hFFFF_FF00, 32'd300);
    n = 0;
    while (!done && n < 100) begin
      if (n == 5) begin
        start = 1'b1; op = OP_DIVU; a = 32'h55; b = 32'd0;
      end else if (n == 9) begin
        start = 1'b1; op = OP_MTHI; a = 32'hBAD0_BAD0; b = 32'd1;
      end else begin
        start = 1'b0;
      end
      @(posedge clk);
      #1;
      n++;
    end
    start = 1'b0;
    check("busy_start_latency", 64'(n), 64'd33);
    check("busy_start_result", {hi, lo}, exp);
    {m_hi, m_lo} = exp;

    // Flush at counter 10: back to IDLE, HI/LO unchanged, no done.
    issue(OP_MULTU, 32'd1234, 32'd5678);
    repeat (10) begin
      @(posedge clk);
      #1;
    end
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    check("flush_busy", 64'(busy), 64'd0);
    check("flush_hilo", {hi, lo}, {m_hi, m_lo});
    seen_done = 1'b0;
    repeat (40) begin
      if (done) seen_done = 1'b1;
      @(posedge clk);
      #1;
    end
    check("flush_no_done", 64'(seen_done), 64'd0);
    check("flush_hilo_late", {hi, lo}, {m_hi, m_lo});

    // Flush and start together in IDLE: request dropped.
    @(negedge clk);
    flush = 1'b1; start = 1'b1; op = OP_MTHI; a = 32'hDEAD_BEEF;
    @(posedge clk);
    #1;
    flush = 1'b0; start = 1'b0;
    check("flush_start_hilo", {hi, lo}, {m_hi, m_lo});
    check("flush_start_busy", 64'(busy), 64'd0);

    // Random ops against the model.
    for (int i = 0; i < 24; i++) begin
      r_op = 3'($urandom_range(0, 7));
      r_a  = $urandom;
      r_b  = ($urandom_range(0, 4) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 3) == 0) r_b = 32'($urandom_range(1, 15));
      do_op(r_op, r_a, r_b, "rand");
    end

    // Reset mid-divide between edges takes effect immediately.
    issue(OP_DIV, 32'd100, 32'd7);
    repeat (5) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_done", 64'(done), 64'd0);
    check("midrst_hilo", {hi, lo}, 64'd0);
    rst = 1'b0;
    m_hi = '0; m_lo = '0;
    do_op(OP_MULTU, 32'd2, 32'd3, "post_rst_multu");
    check("post_rst_const", {hi, lo}, 64'd6);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
